// File: rtl/dmem_bridge.sv
// Data-memory bridge: CPU byte-addressed load/store port onto a word-organised RAM
// with configurable access latency, lane-masked writes and fault detection.
module dmem_bridge #(
    parameter logic [31:0] DATA_BASE  = 32'h10010000,
    parameter int unsigned DEPTH_LOG2 = 11,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        cpu_stall,
    output logic        fault_sticky
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    we_q, signed_q;
    logic [1:0]              size_q, lane_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              fault_q, fault_d;
    logic                    sticky_q, sticky_d;
    logic                    latch_en, access;

    logic [31:0] mem [Words];

    logic [31:0] offset;
    logic [1:0]  req_fault;

    assign offset = req_addr - DATA_BASE;

    always_comb begin
        req_fault = 2'b00;
        if (req_size == 2'b11) begin
            req_fault = 2'b11;
        end else if ((req_size == 2'b01 && offset[0]) ||
                     (req_size == 2'b10 && offset[1:0] != 2'b00)) begin
            req_fault = 2'b01;
        end else if (offset[31:DEPTH_LOG2+2] != '0) begin
            // Unsigned compare: addresses below DATA_BASE wrap to huge offsets.
            req_fault = 2'b10;
        end
    end

    // Load path: lane extraction and extension from the addressed word.
    logic [31:0] rd_word, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign rd_word  = mem[idx_q];
    assign half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        byte_sel = rd_word[7:0];
        unique case (lane_q)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
    end

    always_comb begin
        load_data = rd_word;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Store path: byte enables and replicated data so any lane lines up.
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mem_we;

    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << lane_q;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = lane_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign mem_we = access & we_q & ~reset;

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        sticky_d = sticky_q;
        latch_en = 1'b0;
        access   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    rdata_d  = 32'h0;
                    if (req_fault != 2'b00) begin
                        state_d  = StResp;
                        fault_d  = req_fault;
                        sticky_d = 1'b1;
                    end else begin
                        state_d = StBusy;
                        fault_d = 2'b00;
                        cnt_d   = 3'(LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    access  = 1'b1;
                    state_d = StResp;
                    rdata_d = we_q ? 32'h0 : load_data;
                    fault_d = 2'b00;
                end
            end
            StResp: begin
                state_d = StIdle;
                rdata_d = 32'h0;
                fault_d = 2'b00;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            rdata_q  <= 32'h0;
            fault_q  <= 2'b00;
            sticky_q <= 1'b0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            lane_q   <= 2'b00;
            idx_q    <= '0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            sticky_q <= sticky_d;
            if (latch_en) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                lane_q   <= offset[1:0];
                idx_q    <= offset[DEPTH_LOG2+1:2];
                wdata_q  <= req_wdata;
            end
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = (state_q == StResp);
    assign resp_rdata   = rdata_q;
    assign resp_fault   = fault_q;
    assign fault_sticky = sticky_q;
    assign cpu_stall    = req_valid & ~resp_valid;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
Parametrised data-memory subsystem between the single-cycle CPU data port and an internal word-organised RAM. Translates MARS byte addresses (data segment base) to word indices and supports byte/half/word loads and stores with sign/zero extension and lane-masked writes. Configurable access latency with a valid/ready handshake and CPU stall output. Detects illegal, misaligned and out-of-range accesses.

Parameters:
DATA_BASE, 32'h10010000, byte address mapped to word 0
DEPTH_LOG2, 11, log2 of RAM depth in 32-bit words (2048 words = 8 KiB)
LATENCY, 1, busy cycles per non-faulting access; legal range 1..8

Ports:
clk_in  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU requests an access; held stable until resp_valid
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
req_addr  in  32  MARS byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_ready  out  1  bridge idle, request accepted this cycle if req_valid
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size
cpu_stall  out  1  combinational: req_valid & ~resp_valid
fault_sticky  out  1  set on any faulting response, cleared only by reset

Behaviour:
- Reset (sync): state IDLE, resp_valid 0, resp_rdata 0, resp_fault 00, fault_sticky 0, busy counter 0. RAM contents not reset (undefined until written).
- States: IDLE, BUSY, RESP. req_ready = (state==IDLE).
- IDLE: req_valid at edge -> latch we/size/signed/addr/wdata, evaluate fault. Fault -> RESP; else BUSY with counter = LATENCY-1.
- BUSY: counter!=0 -> decrement; counter==0 -> perform access at this edge, go RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. New request cannot be accepted in RESP.
- Timing: accepted in cycle N -> resp_valid in cycle N+LATENCY+1; faulting request -> cycle N+1. Throughput one access per LATENCY+2 cycles.
- Translation: offset = req_addr - DATA_BASE (32-bit, wraps); word index = offset[DEPTH_LOG2+1:2]; lane = offset[1:0].
- Fault priority: size==11 -> 11; else half with lane[0]=1 or word with lane!=00 -> 01; else offset >= 4<<DEPTH_LOG2 (unsigned, so addresses below DATA_BASE fault) -> 10. Faulting access never modifies RAM.
- Stores (little-endian): byte writes lane byte only (wdata[7:0] to bits 8*lane+7:8*lane); half writes bits [15:0] (lane 0) or [31:16] (lane 2); word writes all. Untouched bytes preserved.
- Loads: extract lane byte/half, extend per req_signed (ignored for word). Data sampled at access edge, so a store completed earlier is always visible.
- resp_rdata/resp_fault held registered through RESP; return to 0/00 in IDLE.
- Reset mid-transaction (BUSY or RESP): request dropped, no resp_valid, store not performed if reset coincides with or precedes the access edge.
- req_valid dropped while BUSY: protocol violation; bridge completes the latched access anyway.

Test Plan:
- LATENCY=1: sw 0xDEADBEEF @0x10010004 accepted cycle N -> resp_valid cycle N+2, fault 00; lw @0x10010004 -> rdata 0xDEADBEEF.
- Byte/half merge: sw 0x11223344 @0x10010000; sb 0xAA @0x10010001; sh 0x5566 @0x10010002; lw -> 0x5566AA44.
- Extension: after above, lb @0x10010001 signed -> 0xFFFFFFAA, unsigned -> 0x000000AA; lh @0x10010002 signed -> 0x00005566.
- Faults: lw @0x10010002 -> 01 at N+1; lw @0x1000FFFC -> 10; lw @0x10012000 (DEPTH_LOG2=11) -> 10; size 11 @0x10010003 -> 11; RAM unchanged, fault_sticky=1.
- LATENCY=4: sw then lw same address -> each resp_valid at N+5, cpu_stall high N..N+4, low N+5; req_ready low N+1..N+5.
- Reset in BUSY of sw 0x12345678 @0x10010008 (LATENCY=4, prior data 0) -> no resp_valid, outputs reset; later lw -> 0x00000000.
